// File: rtl/gradient_mac_sequencer_if.sv
// gradient_mac_sequencer_if: start/status, XT and Xtheta_Y memory ports and gradient result stream
interface gradient_mac_sequencer_if #(
  parameter int M = 20,
  parameter int N = 3
);
  localparam int XT_AW = $clog2(N*M);
  localparam int E_AW = $clog2(M);
  localparam int IW = $clog2(N) + 1;
  logic start, busy, done;
  logic [XT_AW-1:0] xt_addr;
  logic signed [15:0] xt_data;
  logic [E_AW-1:0] e_addr;
  logic signed [31:0] e_data;
  logic grad_valid, grad_ready;
  logic [IW-1:0] grad_idx;
  logic signed [31:0] grad_data;
  modport master (
    input start, xt_data, e_data, grad_ready,
    output busy, done, xt_addr, e_addr, grad_valid, grad_idx, grad_data
  );
  modport slave (
    output start, xt_data, e_data, grad_ready,
    input busy, done, xt_addr, e_addr, grad_valid, grad_idx, grad_data
  );
endinterface

// File: rtl/gradient_mac_sequencer.sv
// gradient_mac_sequencer: one-MAC XT*Xtheta_Y gradient sequencer; define GRAD_SAT_EN for saturating accumulation
module gradient_mac_sequencer #(
  parameter int M = 20,
  parameter int N = 3,
  localparam int XT_AW = $clog2(N*M),
  localparam int E_AW = $clog2(M)
) (
  input logic clk,
  input logic rst,
  gradient_mac_sequencer_if.master bus
);
  localparam int IW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
  state_t state;
  logic [IW-1:0] i;
  logic [E_AW-1:0] j;
  logic mac_vld, mac_first;
  logic signed [31:0] acc, prod, acc_next;
  // only the low 32 product bits survive, so a 32x32 multiply of the sign-extended XT element suffices
  assign prod = {{16{bus.xt_data[15]}}, bus.xt_data} * bus.e_data;
`ifdef GRAD_SAT_EN
  logic signed [32:0] sum;
  assign sum = {acc[31], acc} + {prod[31], prod};
  assign acc_next = mac_first ? prod : (sum[32] != sum[31]) ? {sum[32], {31{~sum[32]}}} : sum[31:0];
`else
  assign acc_next = mac_first ? prod : acc + prod;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      mac_vld <= 1'b0;
      mac_first <= 1'b0;
      acc <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.grad_valid <= 1'b0;
      bus.grad_idx <= '0;
      bus.grad_data <= '0;
      bus.xt_addr <= '0;
      bus.e_addr <= '0;
    end else begin
      mac_vld <= state == FETCH;
      mac_first <= state == FETCH && j == '0;
      if (mac_vld) acc <= acc_next;
      case (state)
        IDLE: if (bus.start) begin
          state <= FETCH;
          i <= '0;
          j <= '0;
          bus.busy <= 1'b1;
          bus.xt_addr <= '0;
          bus.e_addr <= '0;
        end
        FETCH: if (j == E_AW'(M-1)) begin
          state <= DRAIN;
          bus.xt_addr <= '0;
          bus.e_addr <= '0;
        end else begin
          j <= j + E_AW'(1);
          bus.xt_addr <= bus.xt_addr + XT_AW'(1);
          bus.e_addr <= bus.e_addr + E_AW'(1);
        end
        DRAIN: begin
          state <= OUT;
          bus.grad_data <= acc_next;
          bus.grad_idx <= i;
          bus.grad_valid <= 1'b1;
        end
        // the done cycle is spent in OUT so a start coinciding with done is not taken
        OUT: if (bus.done) begin
          state <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end else if (bus.grad_valid && bus.grad_ready) begin
          bus.grad_valid <= 1'b0;
          if (i == IW'(N-1)) bus.done <= 1'b1;
          else begin
            state <= FETCH;
            i <= i + IW'(1);
            j <= '0;
            bus.xt_addr <= XT_AW'((32'(i) + 1) * M);
            bus.e_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gradient_mac_sequencer.sv
// tb_gradient_mac_sequencer: randomized bench checking the sequencer against a sum-of-products model
module tb_gradient_mac_sequencer;
  localparam int M = 4;
  localparam int N = 2;
  localparam int MAXC = 200;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  gradient_mac_sequencer_if #(.M(M), .N(N)) bus ();
  gradient_mac_sequencer #(.M(M), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic signed [15:0] xt_mem [N*M];
  logic signed [31:0] e_mem [M];
  always @(posedge clk) begin
    bus.xt_data <= xt_mem[bus.xt_addr];
    bus.e_data <= e_mem[bus.e_addr];
  end
  int n_checks = 0;
  int n_fail = 0;
  logic o_busy [MAXC+1];
  logic o_done [MAXC+1];
  logic o_valid [MAXC+1];
  logic rdy [MAXC+1];
  int o_idx [MAXC+1];
  int o_data [MAXC+1];
  int o_xa [MAXC+1];
  int o_ea [MAXC+1];
  int start_at [$];
  int lo_from = -1, lo_to = -2, rst_at = -1;
  bit rand_rdy = 0;
  int hs_idx [$], hs_data [$], hs_cyc [$], dn_cyc [$];

  function automatic int model_grad(input int r);
    int acc, p;
    longint s;
    acc = 0;
    for (int k = 0; k < M; k++) begin
      p = int'(xt_mem[r*M+k]) * int'(e_mem[k]);
      s = longint'(acc) + longint'(p);
`ifdef GRAD_SAT_EN
      if (k == 0) acc = p;
      else if (s > longint'(32'sh7FFFFFFF)) acc = 32'sh7FFFFFFF;
      else if (s < -longint'(32'sh7FFFFFFF) - 1) acc = 32'sh80000000;
      else acc = int'(s);
`else
      acc = (k == 0) ? p : int'(s);
`endif
    end
    return acc;
  endfunction

  // cycle c observation is taken at the negedge after the edge that ends cycle c-1
  task automatic run(input int ncyc);
    for (int c = 0; c <= ncyc; c++) begin
      o_busy[c] = bus.busy;
      o_done[c] = bus.done;
      o_valid[c] = bus.grad_valid;
      o_idx[c] = int'(bus.grad_idx);
      o_data[c] = bus.grad_data;
      o_xa[c] = int'(bus.xt_addr);
      o_ea[c] = int'(bus.e_addr);
      if (c < ncyc) begin
        bus.start = 0;
        foreach (start_at[q]) if (start_at[q] == c) bus.start = 1;
        rdy[c] = rand_rdy ? ($urandom_range(2) != 0) : !(c >= lo_from && c <= lo_to);
        bus.grad_ready = rdy[c];
        rst = (c == rst_at);
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.start = 0;
    bus.grad_ready = 1;
    rst = 0;
    start_at.delete();
    lo_from = -1;
    lo_to = -2;
    rst_at = -1;
    rand_rdy = 0;
  endtask

  function automatic void collect(input int ncyc);
    hs_idx.delete();
    hs_data.delete();
    hs_cyc.delete();
    dn_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (o_valid[c] && rdy[c]) begin
        hs_idx.push_back(o_idx[c]);
        hs_data.push_back(o_data[c]);
        hs_cyc.push_back(c);
      end
      if (o_done[c]) dn_cyc.push_back(c);
    end
  endfunction

  task automatic load_basic();
    xt_mem[0] = 1; xt_mem[1] = 2; xt_mem[2] = 3; xt_mem[3] = 4;
    xt_mem[4] = -1; xt_mem[5] = 0; xt_mem[6] = 0; xt_mem[7] = 0;
    e_mem[0] = 10; e_mem[1] = 20; e_mem[2] = 30; e_mem[3] = 40;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.grad_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.grad_valid); end
    n_checks++; if (bus.grad_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.grad_idx); end
    n_checks++; if (bus.grad_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", bus.grad_data); end
    n_checks++; if (bus.xt_addr !== '0) begin n_fail++; $display("FAIL reset_xt_addr: got %0d expected 0", bus.xt_addr); end
    n_checks++; if (bus.e_addr !== '0) begin n_fail++; $display("FAIL reset_e_addr: got %0d expected 0", bus.e_addr); end
    rst = 0;
  endtask

  task automatic test_basic();
    load_basic();
    start_at = '{0};
    run(20);
    collect(20);
    n_checks++; if (hs_data.size() !== N) begin n_fail++; $display("FAIL basic_hs_count: got %0d expected %0d", hs_data.size(), N); end
    for (int r = 0; r < N && r < hs_data.size(); r++) begin
      n_checks++; if (hs_idx[r] !== r) begin n_fail++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", r, hs_idx[r], r); end
      n_checks++; if (hs_data[r] !== model_grad(r)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", r, hs_data[r], model_grad(r)); end
    end
    n_checks++; if (hs_data.size() > 0 && hs_data[0] !== 300) begin n_fail++; $display("FAIL basic_row0: got %0d expected 300", hs_data[0]); end
    n_checks++; if (dn_cyc.size() !== 1 || dn_cyc[0] !== 1 + N*(M+2)) begin n_fail++; $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at %0d", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] : -1, 1 + N*(M+2)); end
    for (int c = 0; c <= 16; c++) begin
      n_checks++; if (o_busy[c] !== (c >= 1 && c <= 1 + N*(M+2))) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b", c, o_busy[c]); end
    end
  endtask

  task automatic test_address();
    int xa, ea;
    foreach (xt_mem[k]) xt_mem[k] = 16'($urandom);
    foreach (e_mem[k]) e_mem[k] = $urandom;
    start_at = '{0};
    run(20);
    for (int c = 0; c <= 20; c++) begin
      xa = 0;
      ea = 0;
      for (int r = 0; r < N; r++)
        if (c >= 1 + r*(M+2) && c <= M + r*(M+2)) begin
          ea = c - 1 - r*(M+2);
          xa = r*M + ea;
        end
      n_checks++; if (o_xa[c] !== xa || o_ea[c] !== ea) begin n_fail++; $display("FAIL addr[%0d]: got %0d/%0d expected %0d/%0d", c, o_xa[c], o_ea[c], xa, ea); end
    end
  endtask

  task automatic test_backpressure();
    load_basic();
    start_at = '{0};
    lo_from = M + 2;
    lo_to = M + 6;
    run(26);
    collect(26);
    for (int c = M + 2; c <= M + 7; c++) begin
      n_checks++; if (o_valid[c] !== 1'b1 || o_data[c] !== model_grad(0) || o_idx[c] !== 0 || o_xa[c] !== 0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%0d idx=%0d xa=%0d expected 1/%0d/0/0", c, o_valid[c], o_data[c], o_idx[c], o_xa[c], model_grad(0));
      end
    end
    n_checks++; if (dn_cyc.size() !== 1 || dn_cyc[0] !== 6 + N*(M+2)) begin n_fail++; $display("FAIL bp_done: got %0d pulses first at %0d expected 1 at %0d", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] : -1, 6 + N*(M+2)); end
    n_checks++; if (hs_data.size() !== N || hs_data[N-1] !== model_grad(N-1)) begin n_fail++; $display("FAIL bp_stream: got %0d handshakes expected %0d", hs_data.size(), N); end
  endtask

  task automatic test_overflow();
`ifdef GRAD_SAT_EN
    int ovf_exp = 32'sh7FFFFFFF;
`else
    int ovf_exp = 32'hFFFE0004;
`endif
    for (int k = 0; k < M; k++) begin
      xt_mem[k] = 16'sd32767;
      xt_mem[M+k] = 16'($urandom);
      e_mem[k] = 32'sh7FFFFFFF;
    end
    start_at = '{0};
    run(20);
    collect(20);
    n_checks++; if (hs_data.size() !== N) begin n_fail++; $display("FAIL ovf_hs_count: got %0d expected %0d", hs_data.size(), N); end
    n_checks++; if (hs_data.size() > 0 && hs_data[0] !== ovf_exp) begin n_fail++; $display("FAIL ovf_row0: got %h expected %h", hs_data[0], ovf_exp); end
    n_checks++; if (hs_data.size() > 1 && hs_data[1] !== model_grad(1)) begin n_fail++; $display("FAIL ovf_row1: got %h expected %h", hs_data[1], model_grad(1)); end
  endtask

  task automatic test_start_ignored();
    load_basic();
    start_at = '{0, M + 4, 1 + N*(M+2), 2 + N*(M+2)};
    run(34);
    collect(34);
    n_checks++; if (dn_cyc.size() !== 2) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 2", dn_cyc.size()); end
    n_checks++; if (dn_cyc.size() == 2 && dn_cyc[1] !== 3 + 2*N*(M+2)) begin n_fail++; $display("FAIL ign_done2: got %0d expected %0d", dn_cyc[1], 3 + 2*N*(M+2)); end
    n_checks++; if (o_busy[2 + N*(M+2)] !== 1'b0) begin n_fail++; $display("FAIL ign_gap_busy: got %b expected 0", o_busy[2 + N*(M+2)]); end
    n_checks++; if (hs_data.size() !== 2*N) begin n_fail++; $display("FAIL ign_hs_count: got %0d expected %0d", hs_data.size(), 2*N); end
    for (int h = 0; h < hs_data.size() && h < 2*N; h++) begin
      n_checks++; if (hs_data[h] !== model_grad(h % N)) begin n_fail++; $display("FAIL ign_data[%0d]: got %0d expected %0d", h, hs_data[h], model_grad(h % N)); end
    end
  endtask

  task automatic test_mid_reset();
    load_basic();
    start_at = '{0, 8};
    rst_at = M + 1;
    run(26);
    collect(26);
    n_checks++; if (o_busy[M+2] !== 1'b0 || o_valid[M+2] !== 1'b0) begin n_fail++; $display("FAIL mrst_after: got busy=%b valid=%b expected 0/0", o_busy[M+2], o_valid[M+2]); end
    n_checks++; if (dn_cyc.size() !== 1 || dn_cyc[0] !== 9 + N*(M+2)) begin n_fail++; $display("FAIL mrst_done: got %0d pulses first at %0d expected 1 at %0d", dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] : -1, 9 + N*(M+2)); end
    n_checks++; if (hs_data.size() !== N) begin n_fail++; $display("FAIL mrst_hs_count: got %0d expected %0d", hs_data.size(), N); end
    for (int r = 0; r < N && r < hs_data.size(); r++) begin
      n_checks++; if (hs_data[r] !== model_grad(r)) begin n_fail++; $display("FAIL mrst_data[%0d]: got %0d expected %0d", r, hs_data[r], model_grad(r)); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      foreach (xt_mem[k]) xt_mem[k] = 16'($urandom);
      foreach (e_mem[k]) e_mem[k] = $urandom;
      start_at = '{0};
      rand_rdy = 1;
      run(100);
      collect(100);
      n_checks++; if (hs_data.size() !== N) begin n_fail++; $display("FAIL rnd%0d_hs_count: got %0d expected %0d", it, hs_data.size(), N); end
      for (int r = 0; r < N && r < hs_data.size(); r++) begin
        n_checks++; if (hs_idx[r] !== r || hs_data[r] !== model_grad(r)) begin n_fail++; $display("FAIL rnd%0d_row%0d: got idx=%0d data=%0d expected %0d/%0d", it, r, hs_idx[r], hs_data[r], r, model_grad(r)); end
      end
      n_checks++; if (dn_cyc.size() !== 1 || hs_cyc.size() == 0 || dn_cyc[0] !== hs_cyc[hs_cyc.size()-1] + 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d pulses first at %0d", it, dn_cyc.size(), dn_cyc.size() ? dn_cyc[0] : -1); end
      for (int c = 0; c < 100; c++)
        if (o_valid[c] && !rdy[c]) begin
          n_checks++; if (o_valid[c+1] !== 1'b1 || o_data[c+1] !== o_data[c] || o_idx[c+1] !== o_idx[c]) begin n_fail++; $display("FAIL rnd%0d_hold[%0d]: got valid=%b data=%0d expected 1/%0d", it, c+1, o_valid[c+1], o_data[c+1], o_data[c]); end
        end
    end
  endtask

  initial begin
    bus.start = 0;
    bus.grad_ready = 1;
    foreach (xt_mem[k]) xt_mem[k] = 0;
    foreach (e_mem[k]) e_mem[k] = 0;
    test_reset();
    test_basic();
    test_address();
    test_backpressure();
    test_overflow();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
